// File: rtl/processor_pkg.sv
// Shared definitions for the processor slice: program-loader FSM encoding and
// default frame parameters.
package processor_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } loader_state_t;

  localparam logic [7:0]  DEFAULT_HEADER    = 8'hA5;
  localparam int unsigned DEFAULT_MAX_WORDS = 64;

  // A word count is usable when it is non-zero and fits the program space.
  function automatic logic count_ok(input logic [7:0] n, input int unsigned max_words);
    return (n != 8'd0) && ({24'd0, n} <= max_words);
  endfunction

endpackage

// File: rtl/program_loader.sv
// Byte-stream program loader: parses HEADER / count / big-endian words / XOR
// checksum frames, writes words into instruction memory and holds the CPU in clear.
module program_loader
  import processor_pkg::*;
#(
  parameter logic [7:0]  HEADER    = DEFAULT_HEADER,
  parameter int unsigned MAX_WORDS = DEFAULT_MAX_WORDS
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        prog_write,
  output logic [7:0]  prog_addr,
  output logic [31:0] prog_data,
  output logic        cpu_clr,
  output logic        done,
  output logic        error
);

  loader_state_t state;
  logic [7:0]  n_words;
  logic [7:0]  word_cnt;
  logic [1:0]  byte_cnt;
  logic [7:0]  addr;
  logic [23:0] asm_reg;
  logic [7:0]  chk;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= S_IDLE;
      rx_ready   <= 1'b1;
      prog_write <= 1'b0;
      prog_addr  <= '0;
      prog_data  <= '0;
      cpu_clr    <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      n_words    <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      addr       <= '0;
      asm_reg    <= '0;
      chk        <= '0;
    end else begin
      prog_write <= 1'b0;
      rx_ready   <= 1'b1;
      // Follows the state register, so the CPU is released one cycle after DONE.
      cpu_clr    <= (state != S_DONE);

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (rx_valid && rx_data == HEADER) begin
            state <= S_COUNT;
            done  <= 1'b0;
            error <= 1'b0;
          end
        end

        S_COUNT: begin
          if (rx_valid) begin
            if (!count_ok(rx_data, MAX_WORDS)) begin
              state <= S_ERROR;
              error <= 1'b1;
            end else begin
              n_words  <= rx_data;
              addr     <= '0;
              byte_cnt <= '0;
              word_cnt <= '0;
              chk      <= '0;
              state    <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (rx_valid) begin
            asm_reg <= {asm_reg[15:0], rx_data};
            chk     <= chk ^ rx_data;
            if (byte_cnt == 2'd3) begin
              byte_cnt   <= '0;
              prog_write <= 1'b1;
              prog_data  <= {asm_reg, rx_data};
              prog_addr  <= addr;
              rx_ready   <= 1'b0;
              state      <= S_WRITE;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end

        S_WRITE: begin
          addr     <= addr + 8'd4;
          word_cnt <= word_cnt + 8'd1;
          state    <= (word_cnt + 8'd1 == n_words) ? S_CHECK : S_DATA;
        end

        S_CHECK: begin
          if (rx_valid) begin
            if (rx_data == chk) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of frames plus hand sequences for
// count boundaries and mid-frame reset.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        prog_write;
  logic [7:0]  prog_addr;
  logic [31:0] prog_data;
  logic        cpu_clr;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  logic [39:0] wq[$];

  program_loader #(.HEADER(8'hA5), .MAX_WORDS(64)) dut (
    .clk(clk), .clr_n(clr_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .prog_write(prog_write), .prog_addr(prog_addr),
    .prog_data(prog_data), .cpu_clr(cpu_clr), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // rx_ready must be low exactly on write cycles; capture every write.
  always @(negedge clk) begin
    if (mon_en) begin
      check("rdy_vs_write", {39'd0, rx_ready}, {39'd0, ~prog_write});
      if (prog_write) wq.push_back({prog_addr, prog_data});
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    int waited;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    waited = 0;
    while (!rx_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_ready) check("rx_ready_timeout", 40'd0, 40'd1);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0]        cnt;
    int                nw;
    logic [2:0][31:0]  w;
    logic [7:0]        chk;
    bit                exp_done;
    bit                gapped;
  } vec_t;

  vec_t tbl[6];

  task automatic run_vec(input vec_t v, input int idx);
    int g;
    logic [7:0] b;
    wq.delete();
    send(8'hA5, 0);
    send(v.cnt, 0);
    for (int i = 0; i < v.nw; i++)
      for (int k = 0; k < 4; k++) begin
        g = v.gapped ? int'($urandom_range(0, 3)) : 0;
        b = v.w[i][31 - 8*k -: 8];
        send(b, g);
      end
    if (v.nw > 0) send(v.chk, 0);
    check($sformatf("v%0d_done", idx), {39'd0, done}, {39'd0, v.exp_done});
    check($sformatf("v%0d_error", idx), {39'd0, error}, {39'd0, ~v.exp_done});
    check($sformatf("v%0d_cpu_clr_entry", idx), {39'd0, cpu_clr}, 40'd1);
    @(posedge clk); #1;
    check($sformatf("v%0d_cpu_clr_next", idx), {39'd0, cpu_clr}, {39'd0, ~v.exp_done});
    check($sformatf("v%0d_nwrites", idx), 40'(wq.size()), 40'(v.nw));
    for (int i = 0; i < v.nw && i < wq.size(); i++)
      check($sformatf("v%0d_write%0d", idx, i), wq[i], {8'(4*i), v.w[i]});
  endtask

  initial begin
    clr_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;

    tbl[0] = '{cnt: 8'h02, nw: 2, w: '0, chk: 8'h2D, exp_done: 1'b1, gapped: 1'b0};
    tbl[0].w[0] = 32'h20080005; tbl[0].w[1] = 32'h00000000;
    tbl[1] = tbl[0]; tbl[1].chk = 8'h29; tbl[1].exp_done = 1'b0;
    tbl[2] = '{cnt: 8'h00, nw: 0, w: '0, chk: 8'h00, exp_done: 1'b0, gapped: 1'b0};
    tbl[3] = '{cnt: 8'h41, nw: 0, w: '0, chk: 8'h00, exp_done: 1'b0, gapped: 1'b0};
    tbl[4] = '{cnt: 8'h01, nw: 1, w: '0, chk: 8'h00, exp_done: 1'b1, gapped: 1'b0};
    tbl[4].w[0] = 32'hA5A5A5A5;
    tbl[5] = '{cnt: 8'h03, nw: 3, w: '0, chk: 8'h62, exp_done: 1'b1, gapped: 1'b1};
    tbl[5].w[0] = 32'h01020304; tbl[5].w[1] = 32'h11223344; tbl[5].w[2] = 32'hDEADBEEF;

    #12;
    check("rst_rx_ready", {39'd0, rx_ready}, 40'd1);
    check("rst_prog_write", {39'd0, prog_write}, 40'd0);
    check("rst_addr_data", {prog_addr, prog_data}, 40'd0);
    check("rst_flags", {37'd0, cpu_clr, done, error}, {37'd0, 3'b100});
    @(negedge clk) clr_n = 1'b1;
    mon_en = 1'b1;

    // Noise bytes in IDLE are ignored.
    send(8'h00, 0);
    send(8'h13, 1);
    check("idle_noise_flags", {37'd0, cpu_clr, done, error}, {37'd0, 3'b100});

    for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

    // Count equal to MAX_WORDS is accepted.
    wq.delete();
    send(8'hA5, 0);
    send(8'h40, 0);
    send(8'h77, 0);
    check("max_count_accepted", {38'd0, done, error}, 40'd0);

    // Reset mid-frame after six data bytes of a two-word frame.
    @(negedge clk) clr_n = 1'b0;
    @(negedge clk) clr_n = 1'b1;
    wq.delete();
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'h20, 0); send(8'h08, 0); send(8'h00, 0); send(8'h05, 0);
    send(8'h00, 0); send(8'h00, 2);
    #2 clr_n = 1'b0;
    #1;
    check("midrst_flags", {37'd0, cpu_clr, done, error}, {37'd0, 3'b100});
    check("midrst_addr_data", {prog_addr, prog_data}, 40'd0);
    check("midrst_nwrites", 40'(wq.size()), 40'd1);
    if (wq.size() > 0) check("midrst_write0", wq[0], {8'h00, 32'h20080005});
    @(negedge clk) clr_n = 1'b1;
    check("midrst_rx_ready", {39'd0, rx_ready}, 40'd1);
    run_vec(tbl[0], 6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
